ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Shares one simple dual-port register file (one write port, one synchronous read port, 1-cycle read latency) between NUM_REQ requesters.
- Write port and read port are arbitrated independently, each round-robin, so one write and one read can complete per cycle.
- Read data is returned to the requester that issued the read, one cycle after grant.
- Sits between client blocks (UART/host/etc.) and a reg_file instance.

Parameters:
DATA_WIDTH, 8, data word width; must match the attached reg_file.
ADDR_WIDTH, 2, address width; must match the attached reg_file.
NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_wr_valid  input  NUM_REQ  per-requester write request
o_wr_ready  output  NUM_REQ  write grant, one-hot or zero
i_wr_addr  input  NUM_REQ*ADDR_WIDTH  packed write addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
i_wr_data  input  NUM_REQ*DATA_WIDTH  packed write data, same packing rule
i_rd_valid  input  NUM_REQ  per-requester read request
o_rd_ready  output  NUM_REQ  read grant, one-hot or zero
i_rd_addr  input  NUM_REQ*ADDR_WIDTH  packed read addresses
o_rsp_valid  output  NUM_REQ  one-hot read-response strobe
o_rsp_data  output  DATA_WIDTH  read response data, shared by all requesters
o_ram_wr_en  output  1  to reg_file write enable
o_ram_w_addr  output  ADDR_WIDTH  to reg_file write address
o_ram_w_data  output  DATA_WIDTH  to reg_file write data
o_ram_r_addr  output  ADDR_WIDTH  to reg_file read address
i_ram_r_data  input  DATA_WIDTH  from reg_file read data

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low on i_reset_n.
- Reset values:
  - o_rsp_valid = 0.
  - Write and read priority pointers = 0 (requester 0 highest priority).
  - While i_reset_n = 0: o_wr_ready = 0, o_rd_ready = 0, o_ram_wr_en = 0.
  - o_ram_w_addr, o_ram_w_data, o_ram_r_addr: 0 when nothing is granted.
- Handshake: a transfer occurs on a rising edge where valid[k] && ready[k].
  - Grants (ready) are combinational from valid and the pointer.
  - Requesters must not make valid depend on ready.
  - Once asserted, valid must stay high with stable addr/data until accepted.
- Round-robin (write and read independently): each side has a pointer p.
  - Search order p, p+1, …, NUM_REQ-1, 0, …, p-1; first asserted valid wins.
  - On a grant to k, p <= (k+1) mod NUM_REQ. With no grant, p holds.
  - Guarantee: any continuously asserted valid is granted within NUM_REQ cycles.
- Write path, combinational in the grant cycle:
  - o_ram_wr_en = |o_wr_ready.
  - o_ram_w_addr and o_ram_w_data are the granted requester's slices.
  - The write lands at the edge ending that cycle.
- Read path:
  - In grant cycle N, o_ram_r_addr = granted address.
  - At edge N+1, the one-hot grant is registered into o_rsp_valid.
  - o_rsp_data = i_ram_r_data (pass-through) and is valid during cycle N+1 only.
  - No response backpressure; the requester must accept when strobed.
  - Throughput: one read per cycle; back-to-back responses to different requesters are allowed.
- Simultaneous write and read to the same address in the same cycle:
  - The read returns the OLD contents (reg_file read-before-write).
  - This is required behaviour; no forwarding.
- Same requester with write and read both valid: both may be granted in the same cycle.
- Reset mid-operation:
  - An in-flight read response is dropped; o_rsp_valid clears asynchronously.
  - Pointers return to 0.
- No request (all valid = 0): no RAM write, pointers hold, o_rsp_valid = 0 next cycle.

Decomposition:
- ram_arbiter_pkg: no typedefs needed beyond localparam IDX_WIDTH = $clog2(NUM_REQ), which stays local to the module; no shared package required.
- One sub-module, rr_arbiter, instantiated twice (write side, read side).
  - Parameter N.
  - Ports: i_clk, i_reset_n, i_req[N], o_gnt[N] (one-hot), o_gnt_idx, o_gnt_valid.
  - Owns the pointer register and the rotate/priority logic.
- Top level does slice muxing, the response register and the RAM port drive.

Test Plan:
- Reset, no requests: o_rsp_valid=0, o_ram_wr_en=0, all ready=0 for 5 cycles after i_reset_n rises.
- Single write then read: req0 writes 0xA5 @ addr 2; req0 reads addr 2 next cycle -> o_rsp_valid=2'b01 one cycle after read grant, o_rsp_data=0xA5.
- Contention, both requesters hold i_wr_valid for 4 cycles (req0 data 0x11 @0, req1 0x22 @1): grants alternate 0,1,0,1 starting with req0 -> read back addr0=0x11, addr1=0x22.
- Same-cycle RAW: addr 3 holds 0x33; req0 writes 0x44 @3 while req1 reads @3 in the same cycle -> req1 gets 0x33; a read one cycle later returns 0x44.
- Back-to-back reads: req0 and req1 read addr 0 and addr 1 on consecutive cycles -> o_rsp_valid = 01 then 10 on consecutive cycles with the matching data.
- Reset mid-read: assert i_reset_n=0 in the cycle after a read grant -> o_rsp_valid drops to 0 immediately; after release, next grant goes to req0.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared defaults and the round-robin pointer helper for the RAM arbiter.
package ram_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_NUM_REQ    = 2;

  // Next priority pointer after requester idx is granted, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module rr_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_gnt_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= N) j = j - N;
      // Grants are held off entirely while reset is asserted.
      if (!w_found && i_req[j] && i_reset_n) begin
        w_found = 1'b1;
        w_idx   = IW'(j);
      end
    end
  end

  assign o_gnt       = w_found ? (N'(1) << w_idx) : '0;
  assign o_gnt_idx   = w_idx;
  assign o_gnt_valid = w_found;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= IW'(rr_next(int'(w_idx), N));
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port register file between NUM_REQ requesters,
// with independent round-robin arbitration for the write and read ports.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NUM_REQ-1:0]            i_wr_valid,
  output logic [NUM_REQ-1:0]            o_wr_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
  input  logic [NUM_REQ-1:0]            i_rd_valid,
  output logic [NUM_REQ-1:0]            o_rd_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_rd_addr,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         o_ram_w_addr,
  output logic [DATA_WIDTH-1:0]         o_ram_w_data,
  output logic [ADDR_WIDTH-1:0]         o_ram_r_addr,
  input  logic [DATA_WIDTH-1:0]         i_ram_r_data
);

  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising edge where valid[k] && ready[k];
  // ready is combinational from valid, valid never depends on ready, and
  // addr/data stay stable until accepted. Responses have no backpressure.

  logic [IDX_WIDTH-1:0] w_wr_idx;
  logic [IDX_WIDTH-1:0] w_rd_idx;
  logic                 w_wr_any;
  logic                 w_rd_any;
  logic [NUM_REQ-1:0]   w_rd_gnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_wr_arb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_wr_valid),
    .o_gnt       (o_wr_ready),
    .o_gnt_idx   (w_wr_idx),
    .o_gnt_valid (w_wr_any)
  );

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_rd_arb (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req       (i_rd_valid),
    .o_gnt       (w_rd_gnt),
    .o_gnt_idx   (w_rd_idx),
    .o_gnt_valid (w_rd_any)
  );

  assign o_rd_ready  = w_rd_gnt;
  assign o_ram_wr_en = w_wr_any;

  always_comb begin
    o_ram_w_addr = '0;
    o_ram_w_data = '0;
    o_ram_r_addr = '0;
    if (w_wr_any) begin
      o_ram_w_addr = i_wr_addr[int'(w_wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      o_ram_w_data = i_wr_data[int'(w_wr_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_rd_any) begin
      o_ram_r_addr = i_rd_addr[int'(w_rd_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The reg_file returns data one edge after the address, so the grant is
  // delayed by the same edge to steer the shared data bus to its requester.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= w_rd_gnt;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = i_ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural read-before-write reg_file.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NR = 2;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid;
  logic [NR*AW-1:0] wr_addr, rd_addr;
  logic [NR*DW-1:0] wr_data;
  logic [DW-1:0] rsp_data, ram_w_data, ram_r_data;
  logic          ram_wr_en;
  logic [AW-1:0] ram_w_addr, ram_r_addr;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .i_rd_valid   (rd_valid),
    .o_rd_ready   (rd_ready),
    .i_rd_addr    (rd_addr),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_ram_wr_en  (ram_wr_en),
    .o_ram_w_addr (ram_w_addr),
    .o_ram_w_data (ram_w_data),
    .o_ram_r_addr (ram_r_addr),
    .i_ram_r_data (ram_r_data)
  );

  // Clock / reset block and reg_file model (synchronous read, read-before-write).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_w_addr] <= ram_w_data;
    ram_r_data <= mem[ram_r_addr];
  end

  // Driver tasks: advance to just after the next edge, then apply inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] v, input logic [1:0] a1, input logic [1:0] a0,
                          input logic [7:0] d1, input logic [7:0] d0);
    wr_valid = v;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
  endtask

  task automatic drive_rd(input logic [1:0] v, input logic [1:0] a1, input logic [1:0] a0);
    rd_valid = v;
    rd_addr  = {a1, a0};
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b00, 2'd0, 2'd0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_wr(2'b11, 2'd1, 2'd0, 8'h22, 8'h11);
    drive_rd(2'b11, 2'd1, 2'd0);
    #1;
    checks++; if (wr_ready !== 2'b00) begin failures++; $display("FAIL reset_wr_ready: got %b expected 00", wr_ready); end
    checks++; if (rd_ready !== 2'b00) begin failures++; $display("FAIL reset_rd_ready: got %b expected 00", rd_ready); end
    checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", ram_wr_en); end
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b00, 2'd0, 2'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL idle_rsp_valid cyc%0d: got %b expected 00", c, rsp_valid); end
      checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("FAIL idle_wr_en cyc%0d: got %b expected 0", c, ram_wr_en); end
      checks++; if ({wr_ready, rd_ready} !== 4'b0000) begin failures++; $display("FAIL idle_ready cyc%0d: got %b expected 0000", c, {wr_ready, rd_ready}); end
      checks++; if (ram_w_addr !== 2'd0 || ram_r_addr !== 2'd0 || ram_w_data !== 8'h00) begin
        failures++; $display("FAIL idle_ram_bus cyc%0d: got w_addr=%0d r_addr=%0d w_data=%h expected 0", c, ram_w_addr, ram_r_addr, ram_w_data);
      end
    end
  endtask

  task automatic test_single();
    next_cycle();
    drive_wr(2'b01, 2'd0, 2'd2, 8'h00, 8'hA5);
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL single_wr_ready: got %b expected 01", wr_ready); end
    checks++; if (ram_wr_en !== 1'b1 || ram_w_addr !== 2'd2 || ram_w_data !== 8'hA5) begin
      failures++; $display("FAIL single_wr_port: got en=%b addr=%0d data=%h expected en=1 addr=2 data=a5", ram_wr_en, ram_w_addr, ram_w_data);
    end
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b01, 2'd0, 2'd2);
    #1;
    checks++; if (rd_ready !== 2'b01 || ram_r_addr !== 2'd2) begin
      failures++; $display("FAIL single_rd_grant: got ready=%b addr=%0d expected ready=01 addr=2", rd_ready, ram_r_addr);
    end
    exp_q.push_back(8'hA5);
    next_cycle();
    drive_rd(2'b00, 2'd0, 2'd0);
    exp_d = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== exp_d) begin
      failures++; $display("FAIL single_rsp: got valid=%b data=%h expected valid=01 data=%h", rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      drive_wr(2'b11, 2'd1, 2'd0, 8'h22, 8'h11);
      #1;
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (wr_ready !== exp_g) begin failures++; $display("FAIL contention_gnt cyc%0d: got %b expected %b", c, wr_ready, exp_g); end
    end
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b01, 2'd0, 2'd0);
    exp_q.push_back(8'h11);
    next_cycle();
    drive_rd(2'b10, 2'd1, 2'd0);
    exp_d = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== exp_d) begin
      failures++; $display("FAIL contention_rd0: got valid=%b data=%h expected valid=01 data=%h", rsp_valid, rsp_data, exp_d);
    end
    exp_q.push_back(8'h22);
    next_cycle();
    drive_rd(2'b00, 2'd0, 2'd0);
    exp_d = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== exp_d) begin
      failures++; $display("FAIL contention_rd1: got valid=%b data=%h expected valid=10 data=%h", rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_raw();
    next_cycle();
    drive_wr(2'b01, 2'd0, 2'd3, 8'h00, 8'h33);
    next_cycle();
    drive_wr(2'b01, 2'd0, 2'd3, 8'h00, 8'h44);
    drive_rd(2'b10, 2'd3, 2'd0);
    #1;
    checks++; if (wr_ready !== 2'b01 || rd_ready !== 2'b10) begin
      failures++; $display("FAIL raw_grants: got wr=%b rd=%b expected wr=01 rd=10", wr_ready, rd_ready);
    end
    exp_q.push_back(8'h33);
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b01, 2'd0, 2'd3);
    exp_d = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b10 || rsp_data !== exp_d) begin
      failures++; $display("FAIL raw_old_data: got valid=%b data=%h expected valid=10 data=%h", rsp_valid, rsp_data, exp_d);
    end
    exp_q.push_back(8'h44);
    next_cycle();
    drive_rd(2'b00, 2'd0, 2'd0);
    exp_d = exp_q.pop_front();
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== exp_d) begin
      failures++; $display("FAIL raw_new_data: got valid=%b data=%h expected valid=01 data=%h", rsp_valid, rsp_data, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_v;
    logic [1:0] rd_v [6];
    logic [1:0] gnt  [6];
    rd_v = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
    gnt  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
    exp_v = 2'b00;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive_rd(rd_v[c], 2'd1, 2'd0);
      #1;
      if (exp_v != 2'b00) begin
        exp_d = exp_q.pop_front();
        checks++; if (rsp_valid !== exp_v || rsp_data !== exp_d) begin
          failures++; $display("FAIL b2b_rsp cyc%0d: got valid=%b data=%h expected valid=%b data=%h", c, rsp_valid, rsp_data, exp_v, exp_d);
        end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL b2b_rsp_idle cyc%0d: got %b expected 00", c, rsp_valid); end
      end
      checks++; if (rd_ready !== gnt[c]) begin failures++; $display("FAIL b2b_gnt cyc%0d: got %b expected %b", c, rd_ready, gnt[c]); end
      if (gnt[c] != 2'b00) exp_q.push_back(gnt[c][0] ? 8'h11 : 8'h22);
      exp_v = gnt[c];
    end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    drive_wr(2'b01, 2'd0, 2'd0, 8'h00, 8'h11);
    drive_rd(2'b01, 2'd0, 2'd0);
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b00, 2'd0, 2'd0);
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL midrst_pre: got %b expected 01", rsp_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midrst_drop: got %b expected 00", rsp_valid); end
    next_cycle();
    rst_n = 1'b1;
    drive_wr(2'b11, 2'd1, 2'd0, 8'h22, 8'h11);
    drive_rd(2'b11, 2'd1, 2'd0);
    #1;
    checks++; if (wr_ready !== 2'b01) begin failures++; $display("FAIL midrst_wr_ptr: got %b expected 01", wr_ready); end
    checks++; if (rd_ready !== 2'b01) begin failures++; $display("FAIL midrst_rd_ptr: got %b expected 01", rd_ready); end
    next_cycle();
    drive_wr(2'b00, 2'd0, 2'd0, 8'h00, 8'h00);
    drive_rd(2'b00, 2'd0, 2'd0);
    checks++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h11) begin
      failures++; $display("FAIL midrst_rsp: got valid=%b data=%h expected valid=01 data=11", rsp_valid, rsp_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    ram_r_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_raw();
    test_back_to_back();
    test_reset_mid_read();
    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
